// File: rtl/fetch_queue.sv
// DLX instruction-fetch front end: owns the fetch PC, issues word requests and buffers returns.
// Define FETCH_STATS_EN to add the saturating empty-cycle counter on stall_count.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0015
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_pc,
  output logic [31:0] inst_id,
  output logic [31:0] pc_plus_four_id,
  output logic        inst_valid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StFlush} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     pc4_mem_q  [DEPTH];
  logic            push, pop;

  // FSM next state and fetch PC; redirect overrides everything else.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!branch && (count_q < DepthCnt)) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_ack) begin
          // An ack coinciding with a redirect is the discarded response.
          state_d = StIdle;
          if (!branch) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (branch) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (imem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (branch) begin
      fetch_pc_d = branch_pc & 32'hFFFF_FFFC;
    end
  end

  assign pop = inst_valid && !stall && !branch;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (branch) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset; count_q alone decides validity.
  always_ff @(negedge clk) begin
    if (rst_n && push) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata;
      pc4_mem_q[wr_ptr_q]  <= fetch_pc_q + 32'd4;
    end
  end

  assign imem_req        = (state_q == StWait);
  assign imem_addr       = fetch_pc_q;
  assign inst_valid      = (count_q != '0);
  assign inst_id         = inst_valid ? inst_mem_q[rd_ptr_q] : NOP_WORD;
  assign pc_plus_four_id = inst_valid ? pc4_mem_q[rd_ptr_q] : 32'd0;

`ifdef FETCH_STATS_EN
  logic [31:0] stall_count_q;

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (!inst_valid && !branch && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: behavioural memory plus an ordered-fetch scoreboard, directed and random.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0015;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch;
  logic [31:0] branch_pc;
  logic [31:0] inst_id;
  logic [31:0] pc_plus_four_id;
  logic        inst_valid;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_count;
`endif

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .NOP_WORD (NOP_WORD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .branch          (branch),
    .branch_pc       (branch_pc),
    .inst_id         (inst_id),
    .pc_plus_four_id (pc_plus_four_id),
    .inst_valid      (inst_valid)
`ifdef FETCH_STATS_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus controls, applied by step() at the next posedge.
  logic        drv_rst, drv_stall, drv_branch;
  logic [31:0] drv_bpc;
  int          mem_lat;
  logic        force_en;
  logic [31:0] force_word;
  logic        chk_en;

  // Memory and reference model state.
  logic        pend, pend_discard;
  logic [31:0] pend_addr;
  int          pend_cnt;
  logic [63:0] model_q [$];
  logic [31:0] exp_fetch;
  logic [31:0] stat_model;
  int          req_count, pop_count;
  logic [31:0] first_req_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // One clock: check outputs against the model, run memory, drive inputs, advance the model.
  task automatic step();
    logic        ack_now, ack_disc;
    logic [31:0] ack_addr, ack_word;
    @(posedge clk);
    ack_now  = 1'b0;
    ack_disc = 1'b0;
    ack_addr = '0;
    ack_word = '0;
    if (chk_en) begin
      checks++;
      if (model_q.size() != 0) begin
        if (inst_valid !== 1'b1 || inst_id !== model_q[0][63:32] ||
            pc_plus_four_id !== model_q[0][31:0]) begin
          errors++;
          $display("FAIL head: got v=%0b inst=%h pc4=%h, want inst=%h pc4=%h", inst_valid,
                   inst_id, pc_plus_four_id, model_q[0][63:32], model_q[0][31:0]);
        end
      end else if (inst_valid !== 1'b0 || inst_id !== NOP_WORD || pc_plus_four_id !== 32'd0) begin
        errors++;
        $display("FAIL empty: got v=%0b inst=%h pc4=%h, want v=0 inst=%h pc4=0", inst_valid,
                 inst_id, pc_plus_four_id, NOP_WORD);
      end
`ifdef FETCH_STATS_EN
      checks++;
      if (stall_count !== stat_model) begin
        errors++;
        $display("FAIL stall_count: got %0d want %0d", stall_count, stat_model);
      end
`endif
    end
    if (!drv_rst) begin
      if (pend && imem_req) begin
        checks++;
        if (imem_addr !== pend_addr) begin
          errors++;
          $display("FAIL addr_stable: got %h want %h", imem_addr, pend_addr);
        end
      end else if (!pend && imem_req === 1'b1) begin
        checks++;
        if (imem_addr !== exp_fetch || model_q.size() >= DEPTH) begin
          errors++;
          $display("FAIL req_addr: got %h occ=%0d want %h occ<%0d", imem_addr, model_q.size(),
                   exp_fetch, DEPTH);
        end
        if (req_count == 0) first_req_addr = imem_addr;
        req_count++;
        pend         = 1'b1;
        pend_addr    = imem_addr;
        pend_cnt     = mem_lat;
        pend_discard = 1'b0;
      end
      if (pend) begin
        if (pend_cnt == 0) begin
          ack_now  = 1'b1;
          ack_addr = pend_addr;
          ack_disc = pend_discard;
          ack_word = force_en ? force_word : mem_word(pend_addr);
          force_en = 1'b0;
          pend     = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
    end
    imem_ack   = ack_now;
    imem_rdata = ack_now ? ack_word : $urandom();
    stall      = drv_stall;
    branch     = drv_branch;
    branch_pc  = drv_bpc;
    rst_n      = !drv_rst;
    if (drv_rst) begin
      model_q.delete();
      exp_fetch  = RESET_PC;
      pend       = 1'b0;
      stat_model = '0;
    end else begin
      if (model_q.size() == 0 && !drv_branch && stat_model != 32'hFFFF_FFFF) stat_model++;
      if (drv_branch) begin
        model_q.delete();
        exp_fetch = drv_bpc & 32'hFFFF_FFFC;
        if (pend) pend_discard = 1'b1;
      end else begin
        if (model_q.size() != 0 && !drv_stall) begin
          void'(model_q.pop_front());
          pop_count++;
        end
        if (ack_now && !ack_disc) begin
          model_q.push_back({ack_word, ack_addr + 32'd4});
          exp_fetch = ack_addr + 32'd4;
        end
      end
    end
  endtask

  task automatic do_reset();
    drv_rst    = 1'b1;
    drv_stall  = 1'b0;
    drv_branch = 1'b0;
    force_en   = 1'b0;
    mem_lat    = 0;
    step();
    step();
    drv_rst = 1'b0;
  endtask

  task automatic test_reset();
    chk_en  = 1'b0;
    drv_rst = 1'b1;
    step();
    step();
    chk_en = 1'b1;
    step();
    checks += 5;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
    if (imem_addr !== RESET_PC) begin
      errors++; $display("FAIL rst_addr: got %h want %h", imem_addr, RESET_PC);
    end
    if (inst_id !== NOP_WORD) begin
      errors++; $display("FAIL rst_inst: got %h want %h", inst_id, NOP_WORD);
    end
    if (pc_plus_four_id !== 32'd0) begin
      errors++; $display("FAIL rst_pc4: got %h want 0", pc_plus_four_id);
    end
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
`ifdef FETCH_STATS_EN
    checks++;
    if (stall_count !== 32'd0) begin
      errors++; $display("FAIL rst_stall_count: got %0d want 0", stall_count);
    end
`endif
    drv_rst = 1'b0;
  endtask

  task automatic test_same_cycle();
    mem_lat   = 0;
    drv_stall = 1'b0;
    req_count = 0;
    step();
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL first_req: got req=%b addr=%h want 1 %h", imem_req, imem_addr, RESET_PC);
    end
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_id !== mem_word(RESET_PC) || pc_plus_four_id !== RESET_PC + 4) begin
      errors++;
      $display("FAIL ack_latency: got v=%b inst=%h pc4=%h want 1 %h %h", inst_valid, inst_id,
               pc_plus_four_id, mem_word(RESET_PC), RESET_PC + 4);
    end
    for (int i = 0; i < 19; i++) step();
    checks++;
    if (req_count != 11) begin
      errors++; $display("FAIL throughput: got %0d requests want 11", req_count);
    end
  endtask

  task automatic test_stall_fill();
    logic [31:0] got [4];
    int          n;
    do_reset();
    drv_stall = 1'b1;
    req_count = 0;
    for (int i = 0; i < 12; i++) step();
    checks += 3;
    if (req_count != DEPTH) begin
      errors++; $display("FAIL fill_reqs: got %0d want %0d", req_count, DEPTH);
    end
    if (imem_req !== 1'b0) begin errors++; $display("FAIL fill_req_low: got %b want 0", imem_req); end
    if (inst_id !== mem_word(RESET_PC)) begin
      errors++; $display("FAIL fill_head: got %h want %h", inst_id, mem_word(RESET_PC));
    end
    drv_stall = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      step();
      if (inst_valid === 1'b1) begin
        got[n] = inst_id;
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL drain_count: got %0d want 4", n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== mem_word(RESET_PC + 32'(4 * k))) begin
          errors++; $display("FAIL drain_order[%0d]: got %h want %h", k, got[k],
                             mem_word(RESET_PC + 32'(4 * k)));
        end
      end
    end
  endtask

  task automatic test_latency3();
    logic prev_v;
    int   back_to_back, valid_cnt;
    do_reset();
    mem_lat      = 3;
    prev_v       = 1'b0;
    back_to_back = 0;
    valid_cnt    = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (prev_v && inst_valid) back_to_back++;
      if (inst_valid) valid_cnt++;
      prev_v = inst_valid;
    end
    checks += 2;
    if (back_to_back != 0) begin
      errors++; $display("FAIL lat3_gap: got %0d back-to-back valids want 0", back_to_back);
    end
    if (valid_cnt < 4) begin
      errors++; $display("FAIL lat3_progress: got %0d instructions want >= 4", valid_cnt);
    end
  endtask

  task automatic test_branch_wait();
    int          bad;
    logic        got;
    logic [31:0] pc4;
    do_reset();
    mem_lat = 2;
    step();
    force_en   = 1'b1;
    force_word = 32'hDEAD_BEEF;
    drv_branch = 1'b1;
    drv_bpc    = 32'h0000_0040;
    step();
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL bw_in_wait: got %b want 1", imem_req); end
    drv_branch = 1'b0;
    req_count  = 0;
    step();
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL bw_flush_req: got %b want 0", imem_req); end
    bad = 0;
    got = 1'b0;
    pc4 = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (inst_valid && inst_id === 32'hDEAD_BEEF) bad++;
      if (inst_valid && !got) begin
        got = 1'b1;
        pc4 = pc_plus_four_id;
      end
    end
    checks += 3;
    if (bad != 0) begin errors++; $display("FAIL bw_dropped: DEADBEEF seen %0d times want 0", bad); end
    if (req_count == 0 || first_req_addr !== 32'h40) begin
      errors++; $display("FAIL bw_target: got %0d reqs first=%h want addr 00000040", req_count,
                         first_req_addr);
    end
    if (!got || pc4 !== 32'h44) begin
      errors++; $display("FAIL bw_pc4: got %h want 00000044", pc4);
    end
  endtask

  task automatic test_branch_ack();
    do_reset();
    mem_lat = 0;
    step();
    drv_branch = 1'b1;
    drv_bpc    = 32'h0000_0103;
    step();
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL ba_in_wait: got %b want 1", imem_req); end
    drv_branch = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL ba_drop: got req=%b v=%b want 0 0", imem_req, inst_valid);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL ba_refetch: got req=%b addr=%h want 1 00000100", imem_req, imem_addr);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_reset_midop();
    logic reached;
    do_reset();
    drv_stall = 1'b1;
    reached   = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      step();
      if (model_q.size() == 3) reached = 1'b1;
    end
    mem_lat = 6;
    for (int i = 0; i < 6 && !pend; i++) step();
    checks++;
    if (!reached || inst_valid !== 1'b1 || imem_req !== 1'b1) begin
      errors++; $display("FAIL midop_setup: got v=%b req=%b want 1 1", inst_valid, imem_req);
    end
    drv_rst = 1'b1;
    step();
    drv_rst   = 1'b0;
    drv_stall = 1'b0;
    mem_lat   = 0;
    step();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC || inst_id !== NOP_WORD ||
        pc_plus_four_id !== 32'd0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: got req=%b addr=%h inst=%h pc4=%h v=%b want reset values",
               imem_req, imem_addr, inst_id, pc_plus_four_id, inst_valid);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL midop_refetch: got req=%b addr=%h want 1 %h", imem_req, imem_addr,
                         RESET_PC);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_random();
    do_reset();
    pop_count = 0;
    for (int i = 0; i < 1500; i++) begin
      drv_stall  = ($urandom_range(3) == 0);
      mem_lat    = $urandom_range(3);
      drv_branch = ($urandom_range(19) == 0);
      drv_bpc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : $urandom();
      drv_rst    = ($urandom_range(299) == 0);
      step();
    end
    drv_rst    = 1'b0;
    drv_branch = 1'b0;
    drv_stall  = 1'b0;
    step();
    checks++;
    if (pop_count < 100) begin
      errors++; $display("FAIL random_progress: got %0d pops want >= 100", pop_count);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = '0;
    stall        = 1'b0;
    branch       = 1'b0;
    branch_pc    = '0;
    drv_rst      = 1'b1;
    drv_stall    = 1'b0;
    drv_branch   = 1'b0;
    drv_bpc      = '0;
    mem_lat      = 0;
    force_en     = 1'b0;
    force_word   = '0;
    chk_en       = 1'b0;
    pend         = 1'b0;
    pend_discard = 1'b0;
    pend_addr    = '0;
    pend_cnt     = 0;
    exp_fetch    = RESET_PC;
    stat_model   = '0;
    req_count    = 0;
    pop_count    = 0;
    first_req_addr = '0;

    test_reset();
    test_same_cycle();
    test_stall_fill();
    test_latency3();
    test_branch_wait();
    test_branch_ack();
    test_reset_midop();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
